// File: rtl/phase_track_pkg.sv
// Shared types and widths for the phase tracking loop: FSM encoding,
// phase/frequency word widths and the phase scaling constant (2^16 = pi).
package phase_track_pkg;

   localparam int PI_VAL  = 1 << 16;
   localparam int PHASE_W = $clog2(PI_VAL) + 1;
   localparam int FREQ_W  = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_CALC   = 3'd2,
      ST_STEP   = 3'd3,
      ST_SETTLE = 3'd4
   } state_t;

   // One extra bit so that -pi still has a representable magnitude.
   function automatic logic [PHASE_W:0] abs_err(input logic [PHASE_W-1:0] e);
      logic [PHASE_W:0] ext;
      ext = {e[PHASE_W-1], e};
      return ext[PHASE_W] ? (~ext + 1'b1) : ext;
   endfunction

endpackage

// File: rtl/phase_err_avg4.sv
// Running mean of the current phase error and the three errors before it;
// reports full once three earlier errors have been collected since the last clear.
module phase_err_avg4
   import phase_track_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               push,
   input  logic [PHASE_W-1:0] err_in,
   output logic [PHASE_W-1:0] avg,
   output logic               full
);

   logic [PHASE_W-1:0]        hist_reg [3];
   logic [1:0]                fill_reg;
   logic signed [PHASE_W+1:0] sum;

   always_comb begin
      sum = $signed({{2{err_in[PHASE_W-1]}}, err_in});
      for (int i = 0; i < 3; i++) begin
         sum = sum + $signed({{2{hist_reg[i][PHASE_W-1]}}, hist_reg[i]});
      end
   end

   // Dropping the two LSBs of the signed sum is the arithmetic shift by two.
   assign avg  = sum[PHASE_W+1:2];
   assign full = (fill_reg == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_reg <= '0;
         for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
      end else if (clr) begin
         fill_reg <= '0;
         for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
      end else if (push) begin
         hist_reg[0] <= err_in;
         hist_reg[1] <= hist_reg[0];
         hist_reg[2] <= hist_reg[1];
         if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
      end
   end

endmodule

// File: rtl/phase_track_ctrl.sv
// Phase tracking loop: nudges a DDS tuning word from phase-difference samples.
// Define PHASE_TRACK_AVG_EN to steer on the mean of the last four errors.
module phase_track_ctrl
   import phase_track_pkg::*;
#(
   parameter logic [FREQ_W-1:0]  F_INIT     = 32'h0100_0000,
   parameter logic [FREQ_W-1:0]  F_MIN      = 32'h0080_0000,
   parameter logic [FREQ_W-1:0]  F_MAX      = 32'h0200_0000,
   parameter int                 GAIN_SHIFT = 4,
   parameter logic [PHASE_W-1:0] DEADBAND   = 17'd64,
   parameter int                 LOCK_CNT   = 8,
   parameter int                 SETTLE_CYC = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [PHASE_W-1:0] phase_set,
   input  logic [PHASE_W-1:0] phase_diff,
   input  logic               phase_diff_done,
   output logic [FREQ_W-1:0]  freq_word,
   output logic               freq_valid,
   output logic               locked,
   output logic               busy
);

   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   state_t              state_reg;
   logic                busy_reg, freq_valid_reg, locked_reg;
   logic                done_reg, done_prev_reg, enable_prev_reg;
   logic [1:0]          arm_reg;
   logic [PHASE_W-1:0]  diff_cap_reg, err_reg;
   logic [LW-1:0]       lock_cnt_reg;
   logic [SW-1:0]       settle_cnt_reg;
   logic [FREQ_W-1:0]   freq_word_reg;

   logic                sample;
   logic [PHASE_W-1:0]  err_calc, err_use;
   logic                err_ready, in_band;
   logic [PHASE_W:0]    err_mag;
   logic signed [FREQ_W+1:0] step_ext, sum_next;
   logic [FREQ_W-1:0]   freq_clamped;
   logic [LW-1:0]       lock_inc;

   // arm_reg keeps the edge detector blind until both history stages hold
   // real samples, so a done level already high at reset release is no edge.
   assign sample = done_reg & ~done_prev_reg & arm_reg[1];

`ifdef PHASE_TRACK_AVG_EN
   phase_err_avg4 u_avg (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_reg == ST_IDLE),
      .push   (state_reg == ST_STEP),
      .err_in (err_reg),
      .avg    (err_use),
      .full   (err_ready)
   );
`else
   assign err_use   = err_reg;
   assign err_ready = 1'b1;
`endif

   always_comb begin
      err_calc = diff_cap_reg - phase_set;
      err_mag  = abs_err(err_use);
      in_band  = (err_mag <= {1'b0, DEADBAND});
      step_ext = $signed({{(FREQ_W + 2 - PHASE_W){err_use[PHASE_W-1]}}, err_use}) >>> GAIN_SHIFT;
      sum_next = $signed({2'b00, freq_word_reg}) + step_ext;
      freq_clamped = sum_next[FREQ_W-1:0];
      if (sum_next < $signed({2'b00, F_MIN})) begin
         freq_clamped = F_MIN;
      end else if (sum_next > $signed({2'b00, F_MAX})) begin
         freq_clamped = F_MAX;
      end
      lock_inc = (lock_cnt_reg == LW'(LOCK_CNT)) ? lock_cnt_reg : lock_cnt_reg + LW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= ST_IDLE;
         busy_reg        <= 1'b0;
         freq_valid_reg  <= 1'b0;
         locked_reg      <= 1'b0;
         done_reg        <= 1'b0;
         done_prev_reg   <= 1'b0;
         arm_reg         <= '0;
         enable_prev_reg <= 1'b0;
         diff_cap_reg    <= '0;
         err_reg         <= '0;
         lock_cnt_reg    <= '0;
         settle_cnt_reg  <= '0;
         freq_word_reg   <= F_INIT;
      end else begin
         done_reg        <= phase_diff_done;
         done_prev_reg   <= done_reg;
         arm_reg         <= {arm_reg[0], 1'b1};
         enable_prev_reg <= enable;
         freq_valid_reg  <= 1'b0;

         if (!enable) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            locked_reg   <= 1'b0;
            lock_cnt_reg <= '0;
         end else if (!enable_prev_reg) begin
            // Restart always begins from the nominal tuning word.
            freq_word_reg  <= F_INIT;
            freq_valid_reg <= 1'b1;
            state_reg      <= ST_WAIT;
            busy_reg       <= 1'b1;
            locked_reg     <= 1'b0;
            lock_cnt_reg   <= '0;
         end else begin
            unique case (state_reg)
               ST_IDLE: begin
                  state_reg <= ST_WAIT;
                  busy_reg  <= 1'b1;
               end
               ST_WAIT: begin
                  if (sample) begin
                     diff_cap_reg <= phase_diff;
                     state_reg    <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  err_reg   <= err_calc;
                  state_reg <= ST_STEP;
               end
               ST_STEP: begin
                  if (!err_ready) begin
                     state_reg <= ST_WAIT;
                  end else if (in_band) begin
                     lock_cnt_reg <= lock_inc;
                     locked_reg   <= (lock_inc == LW'(LOCK_CNT));
                     state_reg    <= ST_WAIT;
                  end else begin
                     freq_word_reg  <= freq_clamped;
                     freq_valid_reg <= 1'b1;
                     lock_cnt_reg   <= '0;
                     locked_reg     <= 1'b0;
                     settle_cnt_reg <= '0;
                     state_reg      <= ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (settle_cnt_reg == SW'(SETTLE_CYC - 1)) begin
                     state_reg <= ST_WAIT;
                  end else begin
                     settle_cnt_reg <= settle_cnt_reg + SW'(1);
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign freq_word  = freq_word_reg;
   assign freq_valid = freq_valid_reg;
   assign locked     = locked_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_phase_track_ctrl.sv
// Bench for phase_track_ctrl: expected tuning words are queued as samples are
// driven and popped by a monitor on every freq_valid pulse.
`timescale 1ns/1ps
module tb_phase_track_ctrl;

   // Clamp limits are pulled in close to F_INIT so both clamps are reachable quickly.
   localparam logic [31:0] F_INIT = 32'h0100_0000;
   localparam logic [31:0] F_MIN  = 32'h00FF_E000;
   localparam logic [31:0] F_MAX  = 32'h0100_1000;
   localparam int          SETTLE = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        done = 1'b0;
   logic [16:0] phase_set = '0;
   logic [16:0] phase_diff = '0;
   logic [31:0] freq_word;
   logic        freq_valid, locked, busy;

   int          checks = 0;
   int          errors = 0;
   int          pulse_count = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model_freq = F_INIT;

   always #500 clk = ~clk;

   phase_track_ctrl #(
      .F_INIT(F_INIT), .F_MIN(F_MIN), .F_MAX(F_MAX), .GAIN_SHIFT(4),
      .DEADBAND(17'd64), .LOCK_CNT(8), .SETTLE_CYC(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .phase_set(phase_set),
      .phase_diff(phase_diff), .phase_diff_done(done), .freq_word(freq_word),
      .freq_valid(freq_valid), .locked(locked), .busy(busy)
   );

   // Scoreboard: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (freq_valid === 1'b1) begin
         pulse_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected_pulse: got freq_word %h, expected no pulse", freq_word);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (freq_word !== e) begin
               errors++;
               $display("FAIL scoreboard_freq: got %h expected %h", freq_word, e);
            end else begin
               $display("pulse freq_word=%h ok", freq_word);
            end
         end
      end
   end

   function automatic int wrap17(input int diff, input int set);
      logic signed [16:0] w;
      w = 17'(diff - set);
      return int'(w);
   endfunction

   function automatic logic [31:0] step_model(input logic [31:0] f, input int err);
      longint s;
      s = longint'(f) + longint'(err >>> 4);
      if (s < longint'(F_MIN)) s = longint'(F_MIN);
      if (s > longint'(F_MAX)) s = longint'(F_MAX);
      return 32'(s);
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_update(input int diff, input int set);
      model_freq = step_model(model_freq, wrap17(diff, set));
      exp_q.push_back(model_freq);
   endtask

   task automatic expect_reload();
      model_freq = F_INIT;
      exp_q.push_back(F_INIT);
   endtask

   task automatic edge_sample(input int diff, input int set, input int hold);
      @(negedge clk);
      phase_diff = 17'(diff);
      phase_set  = 17'(set);
      done       = 1'b1;
      repeat (hold) @(negedge clk);
      done = 1'b0;
   endtask

   task automatic test_reset();
      int base;
      done = 1'b1;
      cycles(3);
      checks++; if (freq_word !== F_INIT) begin errors++; $display("FAIL reset_freq: got %h expected %h", freq_word, F_INIT); end
      checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", freq_valid); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      base = pulse_count;
      rst = 1'b1;
      enable = 1'b1;
      expect_reload();
      @(negedge clk);
      checks++; if (freq_valid !== 1'b1) begin errors++; $display("FAIL reset_enable_pulse: got %b expected 1", freq_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_enable_busy: got %b expected 1", busy); end
      cycles(10);
      checks++; if (pulse_count - base !== 1) begin errors++; $display("FAIL reset_held_done: got %0d pulses expected 1", pulse_count - base); end
      done = 1'b0;
      cycles(3);
      $display("test_reset done");
   endtask

   task automatic test_basic_step();
      expect_update(1600, 0);
      @(negedge clk);
      phase_diff = 17'd1600;
      phase_set  = 17'd0;
      done       = 1'b1;
      cycles(3);
      checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got valid %b expected 0", freq_valid); end
      done = 1'b0;
      @(negedge clk);
      checks++; if (freq_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got valid %b expected 1", freq_valid); end
      checks++; if (freq_word !== 32'h0100_0064) begin errors++; $display("FAIL basic_freq: got %h expected 01000064", freq_word); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got valid %b expected 0", freq_valid); end
      cycles(SETTLE + 20);
      $display("test_basic_step done");
   endtask

   task automatic test_enable_restart();
      expect_update(1600, 0);
      edge_sample(1600, 0, 2);
      cycles(100);
      enable = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b expected 0", busy); end
      checks++; if (freq_word !== 32'h0100_00C8) begin errors++; $display("FAIL disable_hold: got %h expected 010000c8", freq_word); end
      edge_sample(3200, 0, 2);
      cycles(5);
      checks++; if (freq_word !== 32'h0100_00C8) begin errors++; $display("FAIL idle_hold: got %h expected 010000c8", freq_word); end
      enable = 1'b1;
      expect_reload();
      @(negedge clk);
      checks++; if (freq_valid !== 1'b1) begin errors++; $display("FAIL reenable_pulse: got %b expected 1", freq_valid); end
      checks++; if (freq_word !== F_INIT) begin errors++; $display("FAIL reenable_freq: got %h expected %h", freq_word, F_INIT); end
      cycles(5);
      $display("test_enable_restart done");
   endtask

   task automatic test_min_error_clamp();
      logic [31:0] exp_tab [3];
      exp_tab = '{32'h00FF_F000, 32'h00FF_E000, 32'h00FF_E000};
      for (int i = 0; i < 3; i++) begin
         expect_update(-65536, 0);
         edge_sample(-65536, 0, 2);
         cycles(SETTLE + 20);
         checks++;
         if (freq_word !== exp_tab[i]) begin
            errors++;
            $display("FAIL min_error_%0d: got %h expected %h", i, freq_word, exp_tab[i]);
         end
      end
      $display("test_min_error_clamp done");
   endtask

   task automatic test_wrap();
      expect_update(-60000, 60000);
      edge_sample(-60000, 60000, 2);
      cycles(SETTLE + 20);
      checks++; if (freq_word !== 32'h00FF_E2B4) begin errors++; $display("FAIL wrap_freq: got %h expected 00ffe2b4", freq_word); end
      $display("test_wrap done");
   endtask

   task automatic test_lock();
      int base;
      base = pulse_count;
      for (int i = 0; i < 8; i++) begin
         edge_sample(30, 0, 2);
         cycles(4);
         checks++;
         if (locked !== (i == 7)) begin
            errors++;
            $display("FAIL lock_sample_%0d: got locked %b expected %b", i, locked, (i == 7));
         end
      end
      checks++; if (pulse_count !== base) begin errors++; $display("FAIL lock_no_pulse: got %0d pulses expected 0", pulse_count - base); end
      expect_update(1000, 0);
      edge_sample(1000, 0, 2);
      @(negedge clk);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_before_step: got %b expected 1", locked); end
      @(negedge clk);
      checks++; if (locked !== 1'b0 || freq_valid !== 1'b1) begin errors++; $display("FAIL lock_drop: got locked %b valid %b expected 0 1", locked, freq_valid); end
      cycles(SETTLE + 20);
      $display("test_lock done");
   endtask

   task automatic test_max_clamp();
      logic [31:0] exp_tab [3];
      exp_tab = '{32'h0100_07D0, 32'h0100_0FA0, 32'h0100_1000};
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      expect_reload();
      cycles(3);
      for (int i = 0; i < 3; i++) begin
         expect_update(32000, 0);
         edge_sample(32000, 0, 2);
         cycles(SETTLE + 20);
         checks++;
         if (freq_word !== exp_tab[i]) begin
            errors++;
            $display("FAIL max_clamp_%0d: got %h expected %h", i, freq_word, exp_tab[i]);
         end
      end
      $display("test_max_clamp done");
   endtask

   task automatic test_done_held();
      int base;
      base = pulse_count;
      expect_update(-1600, 0);
      edge_sample(-1600, 0, 5000);
      cycles(20);
      checks++; if (pulse_count - base !== 1) begin errors++; $display("FAIL done_held_count: got %0d pulses expected 1", pulse_count - base); end
      checks++; if (freq_word !== 32'h0100_0F9C) begin errors++; $display("FAIL done_held_freq: got %h expected 01000f9c", freq_word); end
      $display("test_done_held done");
   endtask

   task automatic test_settle_ignore();
      int base;
      base = pulse_count;
      expect_update(-1600, 0);
      edge_sample(-1600, 0, 3);
      cycles(500);
      edge_sample(-1600, 0, 3);
      cycles(600);
      checks++; if (pulse_count - base !== 1) begin errors++; $display("FAIL settle_ignore: got %0d pulses expected 1", pulse_count - base); end
      expect_update(-1600, 0);
      edge_sample(-1600, 0, 3);
      cycles(SETTLE + 20);
      checks++; if (pulse_count - base !== 2) begin errors++; $display("FAIL settle_resume: got %0d pulses expected 2", pulse_count - base); end
      checks++; if (freq_word !== 32'h0100_0ED4) begin errors++; $display("FAIL settle_freq: got %h expected 01000ed4", freq_word); end
      $display("test_settle_ignore done");
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      phase_diff = 17'd1600;
      phase_set  = 17'd0;
      done       = 1'b1;
      cycles(2);
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (freq_word !== F_INIT) begin errors++; $display("FAIL abort_freq: got %h expected %h", freq_word, F_INIT); end
      checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", freq_valid); end
      @(negedge clk);
      done = 1'b0;
      rst  = 1'b1;
      expect_reload();
      @(negedge clk);
      checks++; if (freq_valid !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b expected 1", freq_valid); end
      cycles(30);
      $display("test_reset_abort done");
   endtask

   initial begin
      test_reset();
      test_basic_step();
      test_enable_restart();
      test_min_error_clamp();
      test_wrap();
      test_lock();
      test_max_clamp();
      test_done_held();
      test_settle_ignore();
      test_reset_abort();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d outstanding updates expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
